// File: rtl/alu_shift_pkg.sv
// rtl/alu_shift_pkg.sv - shift mode and FSM state encodings for the iterative ALU shifter
package alu_shift_pkg;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_shift_step.sv
// rtl/alu_shift_step.sv - combinational single-step shifter, k bit positions in one mode
module alu_shift_step
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] k,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] data_next,
    output logic             carry_next
);

    // One guard bit beyond the word catches the last bit shifted out (zero when k==0).
    logic [WIDTH:0]     sll_w;
    logic [WIDTH:0]     srl_w;
    logic [WIDTH:0]     sra_w;
    logic [2*WIDTH-1:0] rol_w;

    assign sll_w = {1'b0, data} << k;
    assign srl_w = {data, 1'b0} >> k;
    assign sra_w = $unsigned($signed({data, 1'b0}) >>> k);
    assign rol_w = {data, data} << k;

    always_comb begin
        data_next  = data;
        carry_next = 1'b0;
        case (mode)
            SH_SLL: {carry_next, data_next} = sll_w;
            SH_SRL: {data_next, carry_next} = srl_w;
            SH_SRA: {data_next, carry_next} = sra_w;
            SH_ROL: begin
                data_next  = rol_w[2*WIDTH-1:WIDTH];
                carry_next = (k != '0) && rol_w[WIDTH];
            end
            default: begin
                data_next  = data;
                carry_next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_shift_unit.sv
// rtl/alu_shift_unit.sv - iterative SLL/SRL/SRA/ROL shifter with valid/ready on both sides
module alu_shift_unit
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH),
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             busy
);

    localparam logic [AMT_W:0] STEP_V = (AMT_W+1)'(STEP);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] k;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] step_data;
    logic             step_carry;

    // rem never exceeds WIDTH-1, so the truncated STEP is only picked when it fits.
    assign k        = ({1'b0, rem} > STEP_V) ? STEP_V[AMT_W-1:0] : rem;
    assign in_ready = rst_n && (state == S_IDLE);

    alu_shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .data       (work),
        .k          (k),
        .mode       (mode_q),
        .data_next  (step_data),
        .carry_next (step_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            work      <= '0;
            rem       <= '0;
            mode_q    <= SH_SLL;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        work   <= in_data;
                        rem    <= in_amt;
                        mode_q <= in_mode;
                        busy   <= 1'b1;
                        if (in_amt == '0) begin
                            out_data  <= in_data;
                            out_carry <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    work <= step_data;
                    rem  <= rem - k;
                    if (rem == k) begin
                        out_data  <= step_data;
                        out_carry <= step_carry;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_shift_unit.sv
// tb/tb_alu_shift_unit.sv - self-checking bench for alu_shift_unit at STEP=1 and STEP=4
module tb_alu_shift_unit;
    import alu_shift_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_amt = 3'd0;
    logic [1:0] in_mode = 2'b00;

    logic [1:0]      d_in_ready;
    logic [1:0]      d_out_valid;
    logic [1:0]      d_out_carry;
    logic [1:0]      d_busy;
    logic [1:0][7:0] d_out_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_shift_unit #(.WIDTH(8), .AMT_W(3), .STEP(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready[0]),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(d_out_valid[0]), .out_ready(out_ready), .out_data(d_out_data[0]),
        .out_carry(d_out_carry[0]), .busy(d_busy[0])
    );

    alu_shift_unit #(.WIDTH(8), .AMT_W(3), .STEP(4)) u_dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready[1]),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(d_out_valid[1]), .out_ready(out_ready), .out_data(d_out_data[1]),
        .out_carry(d_out_carry[1]), .busy(d_busy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference result as plain integer arithmetic on the whole amount: {carry, data}.
    function automatic logic [8:0] model_shift(input logic [7:0] d, input int a, input logic [1:0] m);
        int dv, sd, r, c;
        dv = int'(d);
        r  = dv;
        c  = 0;
        if (a != 0) begin
            case (m)
                SH_SLL: begin r = (dv << a) & 255; c = (dv >> (8 - a)) & 1; end
                SH_SRL: begin r = dv >> a; c = (dv >> (a - 1)) & 1; end
                SH_SRA: begin
                    sd = (dv >= 128) ? dv - 256 : dv;
                    r  = (sd >>> a) & 255;
                    c  = (dv >> (a - 1)) & 1;
                end
                default: begin r = ((dv << a) | (dv >> (8 - a))) & 255; c = r & 1; end
            endcase
        end
        return {c[0], r[7:0]};
    endfunction

    // Cycle-level model: phase 0 idle, 1 working, 2 result presented.
    int         m_phase [2] = '{0, 0};
    int         m_cnt   [2] = '{0, 0};
    logic [8:0] m_pend  [2] = '{9'h0, 9'h0};
    logic [8:0] m_exp   [2] = '{9'h0, 9'h0};
    bit         m_known [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            int stepv;
            stepv = (s == 0) ? 1 : 4;
            if (!rst_n) begin
                m_phase[s] = 0;
                m_exp[s]   = 9'h0;
                m_known[s] = 1'b1;
            end else if (m_phase[s] == 0) begin
                if (in_valid) begin
                    m_pend[s] = model_shift(in_data, int'(in_amt), in_mode);
                    m_cnt[s]  = (int'(in_amt) + stepv - 1) / stepv;
                    if (m_cnt[s] == 0) begin
                        m_phase[s] = 2;
                        m_exp[s]   = m_pend[s];
                        m_known[s] = 1'b1;
                    end else begin
                        m_phase[s] = 1;
                    end
                end
            end else if (m_phase[s] == 1) begin
                m_cnt[s]--;
                if (m_cnt[s] == 0) begin
                    m_phase[s] = 2;
                    m_exp[s]   = m_pend[s];
                    m_known[s] = 1'b1;
                end
            end else if (out_ready) begin
                m_phase[s] = 0;
                m_known[s] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            int stepv;
            stepv = (s == 0) ? 1 : 4;
            check($sformatf("s%0d_out_valid@%0d", stepv, cyc), d_out_valid[s], m_phase[s] == 2);
            check($sformatf("s%0d_busy@%0d", stepv, cyc), d_busy[s], m_phase[s] != 0);
            check($sformatf("s%0d_in_ready@%0d", stepv, cyc), d_in_ready[s], rst_n && (m_phase[s] == 0));
            if (m_known[s]) begin
                check($sformatf("s%0d_out_data@%0d", stepv, cyc), d_out_data[s], m_exp[s][7:0]);
                check($sformatf("s%0d_out_carry@%0d", stepv, cyc), d_out_carry[s], m_exp[s][8]);
            end
        end
    end

    typedef struct {
        logic [7:0] d;
        int         a;
        logic [1:0] m;
        logic [7:0] ed;
        logic       ec;
        int         l1;
        int         l4;
    } vec_t;

    vec_t vecs [14] = '{
        '{8'hB5, 3, SH_SLL, 8'hA8, 1'b1, 4, 2},
        '{8'h90, 2, SH_SRA, 8'hE4, 1'b0, 3, 2},
        '{8'h90, 2, SH_SRL, 8'h24, 1'b0, 3, 2},
        '{8'h81, 1, SH_ROL, 8'h03, 1'b1, 2, 2},
        '{8'hB5, 7, SH_SLL, 8'h80, 1'b0, 8, 3},
        '{8'h5A, 0, SH_SLL, 8'h5A, 1'b0, 1, 1},
        '{8'h5A, 0, SH_SRL, 8'h5A, 1'b0, 1, 1},
        '{8'h5A, 0, SH_SRA, 8'h5A, 1'b0, 1, 1},
        '{8'h5A, 0, SH_ROL, 8'h5A, 1'b0, 1, 1},
        '{8'h7F, 7, SH_SRA, 8'h00, 1'b1, 8, 3},
        '{8'h81, 7, SH_ROL, 8'hC0, 1'b0, 8, 3},
        '{8'h80, 7, SH_SRA, 8'hFF, 1'b0, 8, 3},
        '{8'hB5, 4, SH_SRL, 8'h0B, 1'b0, 5, 2},
        '{8'hB5, 5, SH_ROL, 8'hB6, 1'b0, 6, 3}
    };

    task automatic run_op(input vec_t v, input string tag);
        int         acc;
        int         lat  [2];
        bit         seen [2];
        logic [7:0] gd   [2];
        logic       gc   [2];
        check({tag, "_model"}, model_shift(v.d, v.a, v.m), {v.ec, v.ed});
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = v.d; in_amt = v.a[2:0]; in_mode = v.m;
        acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = ~v.d; in_amt = 3'd5; in_mode = ~v.m;
        seen = '{1'b0, 1'b0};
        lat  = '{0, 0};
        gd   = '{8'h0, 8'h0};
        gc   = '{1'b0, 1'b0};
        for (int i = 0; i < 40 && !(seen[0] && seen[1]); i++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                if (d_out_valid[s] && !seen[s]) begin
                    seen[s] = 1'b1;
                    lat[s]  = cyc - acc;
                    gd[s]   = d_out_data[s];
                    gc[s]   = d_out_carry[s];
                end
            end
        end
        for (int s = 0; s < 2; s++) begin
            int stepv;
            stepv = (s == 0) ? 1 : 4;
            check($sformatf("%s_s%0d_result_seen", tag, stepv), seen[s], 1);
            if (seen[s]) begin
                check($sformatf("%s_s%0d_data", tag, stepv), gd[s], v.ed);
                check($sformatf("%s_s%0d_carry", tag, stepv), gc[s], v.ec);
                check($sformatf("%s_s%0d_latency", tag, stepv), lat[s], (s == 0) ? v.l1 : v.l4);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vcount;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset_valid_%0d", s), d_out_valid[s], 0);
            check($sformatf("reset_in_ready_%0d", s), d_in_ready[s], 0);
            check($sformatf("reset_busy_%0d", s), d_busy[s], 0);
            check($sformatf("reset_data_%0d", s), d_out_data[s], 0);
            check($sformatf("reset_carry_%0d", s), d_out_carry[s], 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready_0", d_in_ready[0], 1);
        check("post_reset_in_ready_1", d_in_ready[1], 1);

        for (int n = 0; n < 14; n++) run_op(vecs[n], $sformatf("vec%0d", n));
        repeat (2) @(posedge clk);

        // Back-pressure: results must hold while a stray request is ignored.
        #1 out_ready = 1'b0;
        run_op(vecs[0], "hold");
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            in_valid = (h == 1 || h == 2);
            in_data  = 8'h3C; in_amt = 3'd1; in_mode = SH_SRL;
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                check($sformatf("hold%0d_data_%0d", h, s), d_out_data[s], 8'hA8);
                check($sformatf("hold%0d_carry_%0d", h, s), d_out_carry[s], 1);
                check($sformatf("hold%0d_valid_%0d", h, s), d_out_valid[s], 1);
                check($sformatf("hold%0d_in_ready_%0d", h, s), d_in_ready[s], 0);
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid_still", d_out_valid[0], 1);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("release_in_ready_%0d", s), d_in_ready[s], 1);
            check($sformatf("release_valid_%0d", s), d_out_valid[s], 0);
            check($sformatf("release_busy_%0d", s), d_busy[s], 0);
        end

        // Reset pulse mid-shift aborts the operation.
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'hB5; in_amt = 3'd7; in_mode = SH_SLL;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("abort_valid_%0d", s), d_out_valid[s], 0);
            check($sformatf("abort_busy_%0d", s), d_busy[s], 0);
            check($sformatf("abort_in_ready_%0d", s), d_in_ready[s], 0);
            check($sformatf("abort_data_%0d", s), d_out_data[s], 0);
            check($sformatf("abort_carry_%0d", s), d_out_carry[s], 0);
        end
        rst_n = 1'b1;
        vcount = 0;
        repeat (12) begin
            @(negedge clk);
            vcount += int'(d_out_valid[0]) + int'(d_out_valid[1]);
        end
        check("abort_no_valid", vcount, 0);
        run_op(vecs[0], "post_abort");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
